zorro_master_arbiter_mc: RTL and testbench
==========================================

# zorro_master_arbiter_mc

Parametrised Zorro III bus-master arbiter for the local side of the card. It shares one Zorro III master slot between `NREQ` on-card requesters (SCSI core, DMA engines) using round-robin selection. It performs Zorro III registration and unregistration with single-cycle EBR pulses and holds bus ownership across back-to-back requester handoffs. An idle timeout releases the slot automatically. It sits between the local requesters and the Buster EBR/EBG pins, clocked by the 7 MHz arbitration clock.

## Interface
Parameters:
- `NREQ`, 2: number of local requesters, 1..8.
- `IDLE_UNREG`, 15: C7M cycles with no synchronised request, while registered and not owning, before unregistering. 1..255.
- `IW`, derived: $clog2(NREQ), minimum 1.

Ports:
- `C7M`, in, 1: 7 MHz arbitration clock. All state changes on its rising edge.
- `RESET_n`, in, 1: asynchronous, active-low reset.
- `REQ_n`, in, NREQ: per-requester bus request, active low, asynchronous to C7M.
- `MASTER_n`, in, NREQ: per-requester "driving a cycle now", active low.
- `EBG_n`, in, 1: Zorro bus grant from Buster, active low.
- `FCS`, in, 1: Zorro cycle in progress, 1 = busy.
- `DTACK_n`, in, 1: Zorro data acknowledge, active low.
- `GNT_n`, out, NREQ: one-hot-or-zero local grant, active low.
- `EBR_n`, out, 1: Zorro bus request, pulsed low for exactly 1 cycle.
- `MYBUS_n`, out, 1: card owns the Zorro bus, active low.
- `YIELD`, out, 1: owner must finish its current cycle and release.
- `OWNER`, out, IW: index of the last or current grantee.
- `BMASTER`, out, 1: combinational, equal to ~&MASTER_n.

## Operation
- **Synchroniser.** `sreq[i]` <= ~REQ_n[i] every cycle, one flop. The FSM uses only `sreq`.
- **Bus idle.** `bidle` = ~FCS & DTACK_n.
- **States:** IDLE, REG, REGED, GRANT, HANDOFF, UNREG, UNWAIT.
  - IDLE: if |sreq, go to REG.
  - REG: EBR_n=0 for this cycle only. Then go to REGED and clear the idle counter.
  - REGED: if EBG_n=0, bidle and |sreq, go to GRANT. The new OWNER is the first i with sreq[i]=1, searching from OWNER+1 modulo NREQ upward. Else, if no sreq, increment the idle counter; at IDLE_UNREG go to UNREG. Any sreq clears the counter.
  - GRANT: GNT_n[OWNER]=0 and MYBUS_n=0.
    - If EBG_n=1, YIELD=1 (registered, set the cycle after EBG_n is sampled high).
    - Leave when sreq[OWNER]=0, MASTER_n[OWNER]=1 and bidle.
    - If YIELD=0 and another sreq is pending, go to HANDOFF. Otherwise go to REGED.
  - HANDOFF: all GNT_n=1, MYBUS_n stays 0 for 1 cycle. Then return to GRANT with the next round-robin owner, provided EBG_n=0 and bidle still hold. Otherwise go to REGED and deassert MYBUS_n.
  - UNREG: EBR_n=0 for 1 cycle, then go to UNWAIT.
  - UNWAIT: wait for EBG_n=1, then go to IDLE. Requests arriving here are held and serviced from IDLE.
- **Arbitration.** Round-robin is strict. The requester granted last has the lowest priority at the next selection. NREQ=1 degenerates to a single-requester arbiter.
- **EBR timing.** EBR_n is never low on two consecutive cycles. At least 2 cycles separate a register pulse from an unregister pulse.
- **Simultaneous events.**
  - In REGED, if the counter expires in the same cycle that sreq rises, the request wins and no unregistration occurs.
  - If EBG_n rises in the same cycle as the owner's release, the FSM goes to REGED with no YIELD pulse.

## Timing
- **Reset values:** EBR_n=1, MYBUS_n=1, GNT_n=all 1, YIELD=0, OWNER=NREQ-1 (so requester 0 wins first), FSM=IDLE, counter=0.
- **Asynchronous reset:** an assertion mid-operation forces these values immediately, including mid-GRANT.
- **Grant latency:** REQ_n low before edge k gives sreq=1 after k, EBR_n=0 after k+1, REGED after k+2. GNT_n=0 after k+3 if EBG_n=0 and bidle are sampled at k+3.
- **Release latency:** GNT_n and MYBUS_n deassert 1 cycle after the release condition is sampled.
- **Handoff:** the gap between successive grants is exactly 1 cycle of all-GNT_n=1.
- **Unregistration:** EBR_n pulses IDLE_UNREG+1 cycles after the last sreq=1 in REGED.

## Test plan
- **Single request.** Reset, NREQ=2, hold EBG_n=0 and bidle; drop REQ_n[0] before edge 0. Required: EBR_n low for exactly edge 1 to 2, GNT_n=2'b10 after edge 3, MYBUS_n=0, OWNER=0.
- **Round-robin handoff.** REQ_n=2'b00 while in GRANT for owner 0; owner 0 releases. Required: 1 cycle with GNT_n=2'b11 and MYBUS_n=0, then GNT_n=2'b01, OWNER=1. A subsequent re-request by both grants requester 0 next.
- **Yield.** In GRANT, raise EBG_n. Required: YIELD=1 the next cycle. After the owner releases, GNT_n=all 1, MYBUS_n=1, FSM=REGED, with no handoff even if the other requester is pending.
- **Idle unregistration.** IDLE_UNREG=4, no requests after release. Required: a single EBR_n low pulse 5 cycles into REGED, then UNWAIT. Raising EBG_n returns the FSM to IDLE. A request raised in UNWAIT re-registers only after IDLE.
- **Counter/request race.** Counter at IDLE_UNREG-1 while sreq rises. Required: no EBR_n pulse and the counter cleared.
- **Mid-grant reset.** Assert RESET_n low between edges during GRANT. Required: GNT_n, MYBUS_n and EBR_n all 1 immediately, and the FSM in IDLE after release.

Source files
------------

// File: rtl/zorro_master_arbiter_mc.sv
// rtl/zorro_master_arbiter_mc.sv - Zorro III bus-master arbiter sharing one master slot among NREQ local requesters
module zorro_master_arbiter_mc #(
    parameter int NREQ       = 2,
    parameter int IDLE_UNREG = 15,
    parameter int IW         = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic            C7M,
    input  logic            RESET_n,
    input  logic [NREQ-1:0] REQ_n,
    input  logic [NREQ-1:0] MASTER_n,
    input  logic            EBG_n,
    input  logic            FCS,
    input  logic            DTACK_n,
    output logic [NREQ-1:0] GNT_n,
    output logic            EBR_n,
    output logic            MYBUS_n,
    output logic            YIELD,
    output logic [IW-1:0]   OWNER,
    output logic            BMASTER
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REG,
        S_REGED,
        S_GRANT,
        S_HANDOFF,
        S_UNREG,
        S_UNWAIT
    } state_t;

    state_t          state_q, state_d;
    logic [NREQ-1:0] sreq_q, sreq_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            yield_q, yield_d;
    logic            ebr_n_q, ebr_n_d;
    logic            mybus_n_q, mybus_n_d;
    logic [NREQ-1:0] gnt_n_q, gnt_n_d;

    logic            bidle;
    logic            any_sreq;
    logic            own_sreq;
    logic            own_master_n;
    logic            hi_found;
    logic [IW-1:0]   hi_idx;
    logic [IW-1:0]   lo_idx;
    logic [IW-1:0]   rr_idx;

    assign bidle    = ~FCS & DTACK_n;
    assign any_sreq = |sreq_q;
    assign sreq_d   = ~REQ_n;

    // Request and master status of the current owner, selected without a
    // variable-width index so that any NREQ (including non powers of two) works.
    always_comb begin
        own_sreq     = 1'b0;
        own_master_n = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (IW'(i) == owner_q) begin
                own_sreq     = sreq_q[i];
                own_master_n = MASTER_n[i];
            end
        end
    end

    // Round-robin pick: the lowest requester above the last owner, otherwise
    // wrap to the lowest requester overall. Scanning downwards lets the last
    // hit be the lowest index.
    always_comb begin
        hi_found = 1'b0;
        hi_idx   = owner_q;
        lo_idx   = owner_q;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (sreq_q[i]) begin
                if (i > int'(owner_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = IW'(i);
                end
                lo_idx = IW'(i);
            end
        end
        rr_idx = hi_found ? hi_idx : lo_idx;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        cnt_d   = cnt_q;
        yield_d = yield_q;
        case (state_q)
            S_IDLE: begin
                if (any_sreq) begin
                    state_d = S_REG;
                end
            end
            S_REG: begin
                state_d = S_REGED;
                cnt_d   = 8'd0;
            end
            S_REGED: begin
                // A live request always beats an expiring idle count.
                if (!EBG_n && bidle && any_sreq) begin
                    state_d = S_GRANT;
                    owner_d = rr_idx;
                end else if (any_sreq) begin
                    cnt_d = 8'd0;
                end else if (cnt_q == 8'(IDLE_UNREG)) begin
                    state_d = S_UNREG;
                    cnt_d   = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_GRANT: begin
                if (!own_sreq && own_master_n && bidle) begin
                    yield_d = 1'b0;
                    // Losing the grant on the release edge means no handoff and no yield.
                    if (!yield_q && !EBG_n && any_sreq) begin
                        state_d = S_HANDOFF;
                    end else begin
                        state_d = S_REGED;
                        cnt_d   = 8'd0;
                    end
                end else if (EBG_n) begin
                    yield_d = 1'b1;
                end
            end
            S_HANDOFF: begin
                if (!EBG_n && bidle && any_sreq) begin
                    state_d = S_GRANT;
                    owner_d = rr_idx;
                end else begin
                    state_d = S_REGED;
                    cnt_d   = 8'd0;
                end
            end
            S_UNREG: begin
                state_d = S_UNWAIT;
            end
            S_UNWAIT: begin
                if (EBG_n) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Pin outputs are registered from the next state so they change cleanly on C7M.
    always_comb begin
        ebr_n_d   = ~((state_d == S_REG) || (state_d == S_UNREG));
        mybus_n_d = ~((state_d == S_GRANT) || (state_d == S_HANDOFF));
        gnt_n_d   = '1;
        for (int i = 0; i < NREQ; i++) begin
            if ((state_d == S_GRANT) && (IW'(i) == owner_d)) begin
                gnt_n_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge C7M or negedge RESET_n) begin
        if (!RESET_n) begin
            state_q   <= S_IDLE;
            sreq_q    <= '0;
            owner_q   <= IW'(NREQ - 1);
            cnt_q     <= 8'd0;
            yield_q   <= 1'b0;
            ebr_n_q   <= 1'b1;
            mybus_n_q <= 1'b1;
            gnt_n_q   <= '1;
        end else begin
            state_q   <= state_d;
            sreq_q    <= sreq_d;
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            yield_q   <= yield_d;
            ebr_n_q   <= ebr_n_d;
            mybus_n_q <= mybus_n_d;
            gnt_n_q   <= gnt_n_d;
        end
    end

    assign GNT_n   = gnt_n_q;
    assign EBR_n   = ebr_n_q;
    assign MYBUS_n = mybus_n_q;
    assign YIELD   = yield_q;
    assign OWNER   = owner_q;
    assign BMASTER = ~&MASTER_n;

endmodule

// File: tb/tb_zorro_master_arbiter_mc.sv
// tb/tb_zorro_master_arbiter_mc.sv - table-driven scoreboard bench for zorro_master_arbiter_mc
module tb_zorro_master_arbiter_mc;

    localparam int NREQ       = 2;
    localparam int IDLE_UNREG = 4;
    localparam int IW         = 1;

    logic            C7M = 1'b0;
    logic            RESET_n;
    logic [NREQ-1:0] REQ_n;
    logic [NREQ-1:0] MASTER_n;
    logic            EBG_n;
    logic            FCS;
    logic            DTACK_n;
    logic [NREQ-1:0] GNT_n;
    logic            EBR_n;
    logic            MYBUS_n;
    logic            YIELD;
    logic [IW-1:0]   OWNER;
    logic            BMASTER;

    zorro_master_arbiter_mc #(
        .NREQ       (NREQ),
        .IDLE_UNREG (IDLE_UNREG),
        .IW         (IW)
    ) dut (
        .C7M      (C7M),
        .RESET_n  (RESET_n),
        .REQ_n    (REQ_n),
        .MASTER_n (MASTER_n),
        .EBG_n    (EBG_n),
        .FCS      (FCS),
        .DTACK_n  (DTACK_n),
        .GNT_n    (GNT_n),
        .EBR_n    (EBR_n),
        .MYBUS_n  (MYBUS_n),
        .YIELD    (YIELD),
        .OWNER    (OWNER),
        .BMASTER  (BMASTER)
    );

    always #5 C7M = ~C7M;

    typedef struct packed {
        logic [1:0]    gnt_n;
        logic          ebr_n;
        logic          mybus_n;
        logic          yield;
        logic [IW-1:0] owner;
    } exp_t;

    typedef struct packed {
        logic [1:0] req_n;
        logic [1:0] master_n;
        logic       ebg_n;
        logic       fcs;
        logic       dtack_n;
        exp_t       exp;
    } vec_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    function automatic vec_t mk(input logic [1:0] r, input logic [1:0] m, input logic g,
                                input logic f, input logic d, input logic [1:0] gn,
                                input logic e, input logic my, input logic y,
                                input logic [IW-1:0] o);
        vec_t v;
        v.req_n       = r;
        v.master_n    = m;
        v.ebg_n       = g;
        v.fcs         = f;
        v.dtack_n     = d;
        v.exp.gnt_n   = gn;
        v.exp.ebr_n   = e;
        v.exp.mybus_n = my;
        v.exp.yield   = y;
        v.exp.owner   = o;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, got, want);
    endtask

    task automatic compare_outputs(input string tag, input exp_t e);
        check({tag, ".gnt_n"},   32'(GNT_n),   32'(e.gnt_n));
        check({tag, ".ebr_n"},   32'(EBR_n),   32'(e.ebr_n));
        check({tag, ".mybus_n"}, 32'(MYBUS_n), 32'(e.mybus_n));
        check({tag, ".yield"},   32'(YIELD),   32'(e.yield));
        check({tag, ".owner"},   32'(OWNER),   32'(e.owner));
    endtask

    task automatic step(input vec_t v, input string tag);
        exp_t e;
        REQ_n    = v.req_n;
        MASTER_n = v.master_n;
        EBG_n    = v.ebg_n;
        FCS      = v.fcs;
        DTACK_n  = v.dtack_n;
        exp_q.push_back(v.exp);
        @(posedge C7M);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, ".scoreboard_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            compare_outputs(tag, e);
        end
    endtask

    exp_t rst_exp;

    initial begin
        RESET_n  = 1'b0;
        REQ_n    = 2'b11;
        MASTER_n = 2'b11;
        EBG_n    = 1'b1;
        FCS      = 1'b0;
        DTACK_n  = 1'b1;
        rst_exp  = '{gnt_n: 2'b11, ebr_n: 1'b1, mybus_n: 1'b1, yield: 1'b0, owner: 1'b1};

        // single request -> grant to 0, then round-robin handoffs
        vecs.push_back(mk(2'b10, 2'b11, 0, 0, 1, 2'b11, 1, 1, 0, 1));
        vecs.push_back(mk(2'b10, 2'b11, 0, 0, 1, 2'b11, 0, 1, 0, 1));
        vecs.push_back(mk(2'b10, 2'b11, 0, 0, 1, 2'b11, 1, 1, 0, 1));
        vecs.push_back(mk(2'b10, 2'b11, 0, 0, 1, 2'b10, 1, 0, 0, 0));
        vecs.push_back(mk(2'b00, 2'b10, 0, 0, 1, 2'b10, 1, 0, 0, 0));
        vecs.push_back(mk(2'b01, 2'b11, 0, 0, 1, 2'b10, 1, 0, 0, 0));
        vecs.push_back(mk(2'b01, 2'b11, 0, 0, 1, 2'b11, 1, 0, 0, 0));
        vecs.push_back(mk(2'b01, 2'b11, 0, 0, 1, 2'b01, 1, 0, 0, 1));
        vecs.push_back(mk(2'b00, 2'b01, 0, 0, 1, 2'b01, 1, 0, 0, 1));
        vecs.push_back(mk(2'b10, 2'b11, 0, 0, 1, 2'b01, 1, 0, 0, 1));
        vecs.push_back(mk(2'b10, 2'b11, 0, 0, 1, 2'b11, 1, 0, 0, 1));
        vecs.push_back(mk(2'b10, 2'b11, 0, 0, 1, 2'b10, 1, 0, 0, 0));
        // yield: grant withdrawn while owner 0 holds, requester 1 pending
        vecs.push_back(mk(2'b00, 2'b11, 1, 0, 1, 2'b10, 1, 0, 1, 0));
        vecs.push_back(mk(2'b01, 2'b11, 1, 0, 1, 2'b10, 1, 0, 1, 0));
        vecs.push_back(mk(2'b01, 2'b11, 1, 0, 1, 2'b11, 1, 1, 0, 0));
        vecs.push_back(mk(2'b01, 2'b11, 1, 0, 1, 2'b11, 1, 1, 0, 0));
        vecs.push_back(mk(2'b11, 2'b11, 1, 0, 1, 2'b11, 1, 1, 0, 0));
        // idle unregistration, then request held through UNWAIT
        for (int i = 0; i < 4; i++)
            vecs.push_back(mk(2'b11, 2'b11, 0, 0, 1, 2'b11, 1, 1, 0, 0));
        vecs.push_back(mk(2'b11, 2'b11, 0, 0, 1, 2'b11, 0, 1, 0, 0));
        vecs.push_back(mk(2'b11, 2'b11, 0, 0, 1, 2'b11, 1, 1, 0, 0));
        vecs.push_back(mk(2'b10, 2'b11, 0, 0, 1, 2'b11, 1, 1, 0, 0));
        vecs.push_back(mk(2'b10, 2'b11, 0, 0, 1, 2'b11, 1, 1, 0, 0));
        vecs.push_back(mk(2'b10, 2'b11, 1, 0, 1, 2'b11, 1, 1, 0, 0));
        vecs.push_back(mk(2'b10, 2'b11, 0, 0, 1, 2'b11, 0, 1, 0, 0));
        vecs.push_back(mk(2'b10, 2'b11, 0, 0, 1, 2'b11, 1, 1, 0, 0));
        vecs.push_back(mk(2'b10, 2'b11, 0, 0, 1, 2'b10, 1, 0, 0, 0));
        // EBG_n rises on the release edge: REGED, no yield, no handoff
        vecs.push_back(mk(2'b01, 2'b11, 0, 0, 1, 2'b10, 1, 0, 0, 0));
        vecs.push_back(mk(2'b01, 2'b11, 1, 0, 1, 2'b11, 1, 1, 0, 0));
        vecs.push_back(mk(2'b01, 2'b11, 0, 0, 1, 2'b01, 1, 0, 0, 1));
        // release blocked while FCS busy or DTACK asserted
        vecs.push_back(mk(2'b11, 2'b11, 0, 1, 1, 2'b01, 1, 0, 0, 1));
        vecs.push_back(mk(2'b11, 2'b11, 0, 1, 1, 2'b01, 1, 0, 0, 1));
        vecs.push_back(mk(2'b11, 2'b11, 0, 0, 0, 2'b01, 1, 0, 0, 1));
        vecs.push_back(mk(2'b11, 2'b11, 0, 0, 1, 2'b11, 1, 1, 0, 1));
        // counter expiry races a rising request: request wins, counter restarts
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(2'b11, 2'b11, 1, 0, 1, 2'b11, 1, 1, 0, 1));
        vecs.push_back(mk(2'b10, 2'b11, 1, 0, 1, 2'b11, 1, 1, 0, 1));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(2'b11, 2'b11, 1, 0, 1, 2'b11, 1, 1, 0, 1));
        vecs.push_back(mk(2'b11, 2'b11, 1, 0, 1, 2'b11, 0, 1, 0, 1));
        vecs.push_back(mk(2'b11, 2'b11, 1, 0, 1, 2'b11, 1, 1, 0, 1));
        vecs.push_back(mk(2'b11, 2'b11, 1, 0, 1, 2'b11, 1, 1, 0, 1));
        // re-register from IDLE and get granted again
        vecs.push_back(mk(2'b10, 2'b11, 0, 0, 1, 2'b11, 1, 1, 0, 1));
        vecs.push_back(mk(2'b10, 2'b11, 0, 0, 1, 2'b11, 0, 1, 0, 1));
        vecs.push_back(mk(2'b10, 2'b11, 0, 0, 1, 2'b11, 1, 1, 0, 1));
        vecs.push_back(mk(2'b10, 2'b11, 0, 0, 1, 2'b10, 1, 0, 0, 0));
        vecs.push_back(mk(2'b10, 2'b10, 0, 0, 1, 2'b10, 1, 0, 0, 0));

        @(posedge C7M);
        #1;
        compare_outputs("reset", rst_exp);
        @(negedge C7M);
        RESET_n = 1'b1;

        foreach (vecs[i]) step(vecs[i], $sformatf("v%0d", i));

        // asynchronous reset between edges while granted
        #3;
        RESET_n = 1'b0;
        #1;
        compare_outputs("midreset", rst_exp);
        @(posedge C7M);
        #1;
        compare_outputs("inreset", rst_exp);
        @(negedge C7M);
        RESET_n = 1'b1;
        step(mk(2'b10, 2'b11, 0, 0, 1, 2'b11, 1, 1, 0, 1), "post0");
        step(mk(2'b10, 2'b11, 0, 0, 1, 2'b11, 0, 1, 0, 1), "post1");
        step(mk(2'b10, 2'b11, 0, 0, 1, 2'b11, 1, 1, 0, 1), "post2");
        step(mk(2'b10, 2'b11, 0, 0, 1, 2'b10, 1, 0, 0, 0), "post3");

        // BMASTER is combinational
        MASTER_n = 2'b11; #1; check("bmaster11", 32'(BMASTER), 32'd0);
        MASTER_n = 2'b01; #1; check("bmaster01", 32'(BMASTER), 32'd1);
        MASTER_n = 2'b10; #1; check("bmaster10", 32'(BMASTER), 32'd1);
        MASTER_n = 2'b00; #1; check("bmaster00", 32'(BMASTER), 32'd1);
        MASTER_n = 2'b11;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
